seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered successor to the single-cycle datapath ALU. It adds WIDTH-generic logic, shift and compare operations and an iterative multiplier, with an optional iterative divider. The block sits in the execute stage of the multi-cycle core behind a start/valid handshake. Single-cycle operations complete one clock after issue; MUL/DIV operations stall the issuer for WIDTH iterations.

## Interface
- WIDTH, 32, operand/result width; ≥4, power of two
- SHW, $clog2(WIDTH), shift-amount width (derived, do not override)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Start_i  input  1  issue request; accepted only when Ready_o=1
- ALU_Operation_i  input  4  opcode, sampled on accept
- A_i  input  WIDTH  operand A, sampled on accept
- B_i  input  WIDTH  operand B, sampled on accept
- Ready_o  output  1  block can accept an issue this cycle
- Valid_o  output  1  one-cycle pulse: Result/Zero are fresh
- ALU_Result_o  output  WIDTH  registered result, held until the next completion
- Zero_o  output  1  registered, equals (ALU_Result_o==0)

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 OR, 0011 SLL, 0100 SRL, 0101 AND, 0110 XOR, 0111 SRA, 1000 SLT (signed), 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU. 1110, 1111 and disabled opcodes are unknown.
- Shifts use B[SHW-1:0] only. SRA replicates A[WIDTH-1]. ADD and SUB wrap modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- Unknown opcode: result 0, Zero_o=1, single-cycle latency.
- FSM states:
  - IDLE: Ready_o=1. On Start_i, go to ONE for a single-cycle opcode, MUL for 1010/1011, or DIV for 1100/1101.
  - ONE: result is registered. Go to DONE.
  - MUL: unsigned shift-add, one multiplier bit per cycle for WIDTH cycles using a 2*WIDTH product register. Go to DONE.
  - DIV: restoring division, one quotient bit per cycle for WIDTH cycles. Go to DONE.
  - DONE: Valid_o=1 and Ready_o=1. On Start_i, go directly to the next state for that opcode (back-to-back issue). Otherwise go to IDLE.
- Divide by zero: DIVU returns all-ones and REMU returns A. Latency is unchanged (no early exit).
- Start_i is ignored while Ready_o=0. Operands and opcode come from the internal capture registers, never from live inputs.
- ALU_Result_o and Zero_o update only on the cycle Valid_o rises and are stable otherwise.

## Timing
- Reset (async assert, sync release):
  - state returns to IDLE
  - Ready_o=1, Valid_o=0, ALU_Result_o=0, Zero_o=1
  - all capture, product and quotient registers clear
- Reset asserted mid-operation aborts the operation. No Valid_o is produced for it.
- Let the accept edge be E0. Single-cycle opcodes: Valid_o is high for the cycle after E0+1, i.e. latency is 2 edges from accept to the Valid_o edge.
- MUL/MULHU/DIVU/REMU: WIDTH iteration edges after E0, then the DONE edge. Valid_o is high after edge E0+WIDTH+1.
- Ready_o is low from E0 until Valid_o rises. Ready_o and Valid_o are high in the same cycle, so the throughput for single-cycle ops is one result per 2 cycles.
- Iteration count comes from a SHW+1-bit counter that terminates at exactly WIDTH. The counter must not wrap.

## Configuration
- SEQ_ALU_DIV_EN defined: the DIV state, the divider datapath and opcodes 1100/1101 are present.
- SEQ_ALU_DIV_EN undefined: no divider logic is synthesised. 1100/1101 decode as unknown opcodes (result 0, Zero_o=1, single-cycle latency), and the FSM never enters DIV.

## Test plan
- Reset with WIDTH=32, releasing reset mid-MUL -> Ready_o=1, Valid_o=0, Result=0, Zero_o=1; no stray Valid_o afterwards.
- ADD 0x7FFFFFFF+1; SUB 5-5; SRA 0x80000000>>4 (B=0x24, only 4 used); SLT -1<1 -> 0x80000000 Zero=0; 0 Zero=1; 0xF8000000; 1. Each Valid_o exactly 2 edges after accept.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU on the same operands -> 0xFFFFFFFE. Valid_o at edge 33 after accept; Start_i pulses during busy are ignored.
- With SEQ_ALU_DIV_EN: DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5. Without the macro: DIVU 100/7 -> 0 with Zero=1 after 2 edges.
- Back-to-back: issue ADD 1+2, then assert Start_i in the Valid_o cycle with OR 0xF0|0x0F -> results 3 then 0xFF on consecutive Valid_o pulses 2 edges apart.
- WIDTH=8 instance: MUL 0x10*0x10 -> 0x00, MULHU -> 0x01, SLL 1<<B=0x09 -> 0x02. MUL latency is 9 edges.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU behind a start/valid handshake, with an
// iterative shift-add multiplier and an optional restoring divider (SEQ_ALU_DIV_EN).
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Ready_o,
    output logic             Valid_o,
    output logic [WIDTH-1:0] ALU_Result_o,
    output logic             Zero_o
);

    localparam logic [SHW:0] ITER_END = (SHW+1)'(WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_ONE, S_MUL, S_DIV, S_DONE} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state_q, state_d;
    req_t               req_q;
    logic [SHW:0]       cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   one_res, fin_res;
    logic [SHW-1:0]     shamt;
    logic               accept, iter_done, iterating, load_res;

    function automatic state_t issue_state(input logic [3:0] op);
        case (op)
            4'b1010, 4'b1011: return S_MUL;
`ifdef SEQ_ALU_DIV_EN
            4'b1100, 4'b1101: return S_DIV;
`endif
            default:          return S_ONE;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign iter_done = (cnt_q == ITER_END);

    always_comb begin
        state_d  = state_q;
        Ready_o  = 1'b0;
        Valid_o  = 1'b0;
        load_res = 1'b0;
        case (state_q)
            S_IDLE: begin
                Ready_o = 1'b1;
                if (Start_i) state_d = issue_state(ALU_Operation_i);
            end
            S_ONE: begin
                load_res = 1'b1;
                state_d  = S_DONE;
            end
            S_MUL: begin
                if (iter_done) begin
                    load_res = 1'b1;
                    state_d  = S_DONE;
                end
            end
`ifdef SEQ_ALU_DIV_EN
            S_DIV: begin
                if (iter_done) begin
                    load_res = 1'b1;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                Ready_o = 1'b1;
                Valid_o = 1'b1;
                state_d = Start_i ? issue_state(ALU_Operation_i) : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = Ready_o && Start_i;

`ifdef SEQ_ALU_DIV_EN
    assign iterating = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign iterating = (state_q == S_MUL);
`endif

    // Multiplier sits in prod_q's low half and is consumed LSB-first while
    // partial sums accumulate in the high half.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (prod_q[0] ? req_q.a : {WIDTH{1'b0}})};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q  <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else if (accept) begin
            req_q  <= {ALU_Operation_i, A_i, B_i};
            cnt_q  <= '0;
            prod_q <= {{WIDTH{1'b0}}, B_i};
        end else if (iterating && !iter_done) begin
            cnt_q <= cnt_q + (SHW+1)'(1);
            if (state_q == S_MUL) prod_q <= {mul_sum, prod_q[WIDTH-1:1]};
        end
    end

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] rem_q, quo_q, div_diff;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;

    // Dividend bits shift out of quo_q's top while quotient bits enter its
    // bottom. A zero divisor naturally yields all-ones and rem == A.
    assign div_sh   = {rem_q, quo_q[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, req_q.b});
    assign div_diff = div_sh[WIDTH-1:0] - req_q.b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (accept) begin
            rem_q <= '0;
            quo_q <= A_i;
        end else if (state_q == S_DIV && !iter_done) begin
            rem_q <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], div_ge};
        end
    end
`endif

    assign shamt = req_q.b[SHW-1:0];

    always_comb begin
        one_res = '0;
        case (req_q.op)
            4'b0000: one_res = req_q.a + req_q.b;
            4'b0001: one_res = req_q.a - req_q.b;
            4'b0010: one_res = req_q.a | req_q.b;
            4'b0011: one_res = req_q.a << shamt;
            4'b0100: one_res = req_q.a >> shamt;
            4'b0101: one_res = req_q.a & req_q.b;
            4'b0110: one_res = req_q.a ^ req_q.b;
            4'b0111: one_res = $signed(req_q.a) >>> shamt;
            4'b1000: one_res = {{(WIDTH-1){1'b0}}, $signed(req_q.a) < $signed(req_q.b)};
            4'b1001: one_res = {{(WIDTH-1){1'b0}}, req_q.a < req_q.b};
            default: one_res = '0;
        endcase
    end

    always_comb begin
        fin_res = one_res;
        if (state_q == S_MUL)
            fin_res = req_q.op[0] ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];
`ifdef SEQ_ALU_DIV_EN
        if (state_q == S_DIV)
            fin_res = req_q.op[0] ? rem_q : quo_q;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALU_Result_o <= '0;
            Zero_o       <= 1'b1;
        end else if (load_res) begin
            ALU_Result_o <= fin_res;
            Zero_o       <= (fin_res == '0);
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu at WIDTH=32 and WIDTH=8, checked
// every cycle against a plain-arithmetic model and an expected-completion queue.
`timescale 1ns/1ps
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st32 = 1'b0, st8 = 1'b0;
    logic [3:0]  op32 = '0, op8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        rdy32, vld32, z32, rdy8, vld8, z8;
    logic [31:0] res32;
    logic [7:0]  res8;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] last0 = '0, last1 = '0;

`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(rst_n), .Start_i(st32), .ALU_Operation_i(op32),
        .A_i(a32), .B_i(b32), .Ready_o(rdy32), .Valid_o(vld32),
        .ALU_Result_o(res32), .Zero_o(z32)
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst_n), .Start_i(st8), .ALU_Operation_i(op8),
        .A_i(a8), .B_i(b8), .Ready_o(rdy8), .Valid_o(vld8),
        .ALU_Result_o(res8), .Zero_o(z8)
    );

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
        logic [63:0]        m, ua, ub, r;
        logic signed [63:0] sa, sb;
        int                 sh;
        m  = (64'd1 << w) - 64'd1;
        ua = a & m;
        ub = b & m;
        sh = int'(ub % 64'(w));
        sa = ua[w-1] ? $signed(ua | ~m) : $signed(ua);
        sb = ub[w-1] ? $signed(ub | ~m) : $signed(ub);
        case (op)
            4'h0: r = ua + ub;
            4'h1: r = ua - ub;
            4'h2: r = ua | ub;
            4'h3: r = ua << sh;
            4'h4: r = ua >> sh;
            4'h5: r = ua & ub;
            4'h6: r = ua ^ ub;
            4'h7: r = sa >>> sh;
            4'h8: r = (sa < sb) ? 64'd1 : 64'd0;
            4'h9: r = (ua < ub) ? 64'd1 : 64'd0;
            4'hA: r = ua * ub;
            4'hB: r = (ua * ub) >> w;
            4'hC: r = !DIV_EN ? 64'd0 : ((ub == 0) ? m : ua / ub);
            4'hD: r = !DIV_EN ? 64'd0 : ((ub == 0) ? ua : ua % ub);
            default: r = 64'd0;
        endcase
        return r & m;
    endfunction

    function automatic int lat(input logic [3:0] op, input int w);
        if (op == 4'hA || op == 4'hB) return w + 1;
        if (DIV_EN && (op == 4'hC || op == 4'hD)) return w + 1;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp(input int id, input logic v, input logic r,
                       input logic [63:0] res, input logic z);
        exp_t e;
        int   n;
        bit   ev;
        n = (id == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            if (id == 0) e = q0[0];
            else         e = q1[0];
        end
        ev = (n > 0) && (e.cyc == cyc);
        chk($sformatf("valid%0d", id), 64'(v), 64'(ev));
        chk($sformatf("ready%0d", id), 64'(r), 64'((n == 0) || ev));
        if (ev) begin
            chk($sformatf("result%0d", id), res, e.res);
            chk($sformatf("zero%0d", id), 64'(z), 64'(e.res == 64'd0));
            if (id == 0) begin q0.delete(0); last0 = e.res; end
            else         begin q1.delete(0); last1 = e.res; end
        end else begin
            chk($sformatf("hold%0d", id), res, (id == 0) ? last0 : last1);
            if (n > 0 && e.cyc < cyc) begin
                if (id == 0) q0.delete(0);
                else         q1.delete(0);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                cmp(0, vld32, rdy32, {32'd0, res32}, z32);
                cmp(1, vld8, rdy8, {56'd0, res8}, z8);
            end
        end
    endtask

    // Drive one request; 'exp' is the hand-computed answer and also pins the model.
    task automatic issue(input int id, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
        exp_t e;
        int   w;
        w = (id == 0) ? 32 : 8;
        chk($sformatf("model%0d op=%0h", id, op), model(op, a, b, w), exp);
        if (id == 0) begin st32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
        else         begin st8  = 1'b1; op8  = op; a8  = a[7:0];  b8  = b[7:0];  end
        @(posedge clk);
        #1;
        e.res = exp;
        e.cyc = cyc + lat(op, w);
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
        st32 = 1'b0;
        st8  = 1'b0;
        a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
    endtask

    task automatic wait_done(input int id);
        int n;
        for (int i = 0; i < 100; i++) begin
            n = (id == 0) ? q0.size() : q1.size();
            if (n == 0) return;
            @(posedge clk);
            #1;
        end
        chk($sformatf("timeout%0d", id), 64'd1, 64'd0);
        if (id == 0) q0.delete();
        else         q1.delete();
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready32", 64'(rdy32), 64'd1);
        chk("rst_valid32", 64'(vld32), 64'd0);
        chk("rst_result32", 64'(res32), 64'd0);
        chk("rst_zero32", 64'(z32), 64'd1);
        chk("rst_ready8", 64'(rdy8), 64'd1);
        chk("rst_result8", 64'(res8), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Abort a multiply with reset; nothing may complete afterwards.
        issue(0, 4'hA, 64'h1234, 64'h5678, 64'h0626_0060);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready32", 64'(rdy32), 64'd1);
        chk("abort_valid32", 64'(vld32), 64'd0);
        chk("abort_result32", 64'(res32), 64'd0);
        chk("abort_zero32", 64'(z32), 64'd1);
        q0.delete();
        last0 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        issue(0, 4'h0, 64'h7FFF_FFFF, 64'h1, 64'h8000_0000); wait_done(0);
        issue(0, 4'h1, 64'h5, 64'h5, 64'h0);                 wait_done(0);
        issue(0, 4'h7, 64'h8000_0000, 64'h24, 64'hF800_0000); wait_done(0);
        issue(0, 4'h8, 64'hFFFF_FFFF, 64'h1, 64'h1);         wait_done(0);
        issue(0, 4'h8, 64'h1, 64'hFFFF_FFFF, 64'h0);         wait_done(0);
        issue(0, 4'h9, 64'h1, 64'hFFFF_FFFF, 64'h1);         wait_done(0);
        issue(0, 4'h3, 64'h1, 64'h3F, 64'h8000_0000);        wait_done(0);
        issue(0, 4'h4, 64'h8000_0000, 64'h1F, 64'h1);        wait_done(0);
        issue(0, 4'h5, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'hF000_F000); wait_done(0);
        issue(0, 4'h6, 64'hF0F0_F0F0, 64'hFF00_FF00, 64'h0FF0_0FF0); wait_done(0);
        issue(0, 4'h1, 64'h0, 64'h1, 64'hFFFF_FFFF);         wait_done(0);
        issue(0, 4'hE, 64'h12, 64'h34, 64'h0);               wait_done(0);
        issue(0, 4'hF, 64'hFF, 64'hFF, 64'h0);               wait_done(0);

        // Multiply with Start pulses while busy; they must be ignored.
        issue(0, 4'hA, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1);
        repeat (5) begin
            @(posedge clk);
            #1;
            st32 = 1'b1; op32 = 4'h0; a32 = 32'd1; b32 = 32'd1;
        end
        @(posedge clk);
        #1;
        st32 = 1'b0;
        wait_done(0);
        issue(0, 4'hB, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE); wait_done(0);

`ifdef SEQ_ALU_DIV_EN
        issue(0, 4'hC, 64'd100, 64'd7, 64'd14);        wait_done(0);
        issue(0, 4'hD, 64'd100, 64'd7, 64'd2);         wait_done(0);
        issue(0, 4'hC, 64'd5, 64'd0, 64'hFFFF_FFFF);   wait_done(0);
        issue(0, 4'hD, 64'd5, 64'd0, 64'd5);           wait_done(0);
        issue(1, 4'hC, 64'hFF, 64'h10, 64'h0F);        wait_done(1);
`else
        issue(0, 4'hC, 64'd100, 64'd7, 64'd0);         wait_done(0);
        issue(0, 4'hD, 64'd100, 64'd7, 64'd0);         wait_done(0);
`endif

        // Back-to-back: each new issue lands in the previous Valid_o cycle.
        issue(0, 4'h0, 64'd1, 64'd2, 64'd3);
        @(posedge clk);
        #1;
        issue(0, 4'h2, 64'hF0, 64'h0F, 64'hFF);
        @(posedge clk);
        #1;
        issue(0, 4'hB, 64'h8000_0000, 64'h4, 64'h2);
        wait_done(0);

        issue(1, 4'hA, 64'h10, 64'h10, 64'h00);  wait_done(1);
        issue(1, 4'hB, 64'h10, 64'h10, 64'h01);  wait_done(1);
        issue(1, 4'h3, 64'h01, 64'h09, 64'h02);  wait_done(1);
        issue(1, 4'h7, 64'h80, 64'h03, 64'hF0);  wait_done(1);
        issue(1, 4'h0, 64'hFF, 64'h01, 64'h00);  wait_done(1);
        issue(1, 4'hA, 64'hFF, 64'hFF, 64'h01);  wait_done(1);
        issue(1, 4'h8, 64'h80, 64'h7F, 64'h01);  wait_done(1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
